// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the segment scanner: active-low 7-segment codes
// (bit0 = a ... bit6 = g) and the scan FSM state type.
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CHECK   = 2'd2,
        PRESENT = 2'd3
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Scan-side and value-side signals of the segment scanner.
// master = the scan controller, slave = display source / value consumer.
interface seg_scan_if #(parameter int NDIG = 4);

    logic              en;
    logic [6:0]        seg_n;
    logic [NDIG-1:0]   dig_en;
    logic [4*NDIG-1:0] val;
    logic              val_valid;
    logic              val_ready;
    logic              frame_err;

    modport master (
        input  en, seg_n, val_ready,
        output dig_en, val, val_valid, frame_err
    );

    modport slave (
        output en, seg_n, val_ready,
        input  dig_en, val, val_valid, frame_err
    );

endinterface

// File: rtl/seg_scan_ctrl_seg7_hex_dec.sv
// Active-low 7-segment pattern to hex nibble; unknown patterns flag bad
// and decode to 0.
module seg7_hex_dec
    import seg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       bad
);

    // table lookup of the sixteen legal glyphs
    always_comb begin
        nibble = 4'h0;
        bad    = 1'b0;
        case (seg_n)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: bad    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: enables one digit at a time, samples its
// pattern at the end of the dwell, and presents a debounced multi-digit value.
//
// state   | meaning
// IDLE    | scanning disabled, no digit enabled
// SETTLE  | digit idx enabled, sampled on the last dwell cycle
// CHECK   | one cycle: judge the completed frame, update stability count
// PRESENT | val held on val_valid until accepted; scan paused
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int DWELL  = 8,
    parameter int STABLE = 2
)(
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.master bus
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int DW_W  = $clog2(DWELL);
    localparam int ST_W  = $clog2(STABLE + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STABLE);

    scan_state_t       state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [DW_W-1:0]   dwell;
    logic [ST_W-1:0]   stable_cnt, stable_nxt;
    logic [4*NDIG-1:0] frame, prev_frame, last_val, val_q;
    logic [NDIG-1:0]   frame_bad;
    logic              presented;
    logic [3:0]        nibble;
    logic              bad;
    logic              sample, present_go, accept;

    seg7_hex_dec u_dec (
        .seg_n  (bus.seg_n),
        .nibble (nibble),
        .bad    (bad)
    );

    assign sample = (state == SETTLE) && (dwell == DW_LAST);
    assign accept = (state == PRESENT) && bus.val_ready;

    // stability count the current frame would produce if judged now
    always_comb begin
        stable_nxt = ST_W'(1);
        if (|frame_bad)
            stable_nxt = '0;
        else if (frame == prev_frame)
            stable_nxt = (stable_cnt == ST_MAX) ? ST_MAX : stable_cnt + 1'b1;
    end

    // a repeat of the last presented value is suppressed
    assign present_go = (stable_nxt == ST_MAX) && (!presented || (frame != last_val));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.en) state_nxt = SETTLE;
            SETTLE:  if (!bus.en)
                         state_nxt = IDLE;
                     else if (sample && (idx == IDX_LAST))
                         state_nxt = CHECK;
            CHECK:   if (!bus.en)
                         state_nxt = IDLE;
                     else if (present_go)
                         state_nxt = PRESENT;
                     else
                         state_nxt = SETTLE;
            PRESENT: if (accept) state_nxt = bus.en ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // scan counters, frame capture and presentation bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            dwell      <= '0;
            stable_cnt <= '0;
            frame      <= '0;
            frame_bad  <= '0;
            prev_frame <= '0;
            last_val   <= '0;
            val_q      <= '0;
            presented  <= 1'b0;
        end else begin
            if ((state == SETTLE) && bus.en) begin
                if (sample) begin
                    dwell <= '0;
                    idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    dwell <= dwell + 1'b1;
                end
            end else begin
                dwell <= '0;
                idx   <= '0;
            end

            if (sample) begin
                frame[4*idx +: 4] <= nibble;
                frame_bad[idx]    <= bad;
            end

            if ((state == SETTLE) && !bus.en) begin
                stable_cnt <= '0;
                presented  <= 1'b0;
            end

            if (state == CHECK) begin
                prev_frame <= frame;
                if (!bus.en) begin
                    stable_cnt <= '0;
                    presented  <= 1'b0;
                end else begin
                    stable_cnt <= stable_nxt;
                    if (present_go)
                        val_q <= frame;
                end
            end

            if (accept) begin
                last_val  <= val_q;
                presented <= 1'b1;
            end
        end
    end

    // state-decoded outputs
    always_comb begin
        bus.dig_en    = '0;
        bus.frame_err = 1'b0;
        bus.val_valid = 1'b0;
        case (state)
            SETTLE:  bus.dig_en[idx] = 1'b1;
            CHECK:   bus.frame_err   = |frame_bad;
            PRESENT: bus.val_valid   = 1'b1;
            default: ;
        endcase
    end

    assign bus.val = val_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a display model answers dig_en with per-digit
// patterns; a frame-level reference predicts frame_err, presentation and val.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int NDIG   = 4;
    localparam int DWELL  = 8;
    localparam int STABLE = 2;
    localparam int FRAME  = NDIG * DWELL + 1;

    localparam logic [6:0] CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t_en;
    bit   lat_pending;
    int   ready_delay;

    logic [6:0] disp [NDIG];

    // reference state, at frame granularity
    int                m_stable;
    logic [4*NDIG-1:0] m_prev, m_last, m_val;
    bit                m_has;

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .STABLE(STABLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // display: the enabled digit drives its pattern, otherwise all segments off
    always_comb begin
        bus.seg_n = 7'h7F;
        for (int i = 0; i < NDIG; i++)
            if (bus.dig_en == NDIG'(1 << i)) bus.seg_n = disp[i];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_frame(output bit err, output logic [4*NDIG-1:0] v,
                                        output bit pres);
        logic [3:0] n;
        bit         hit;
        err = 1'b0;
        v   = '0;
        for (int i = 0; i < NDIG; i++) begin
            n   = 4'h0;
            hit = 1'b0;
            for (int k = 0; k < 16; k++)
                if (CODES[k] == disp[i]) begin
                    n   = 4'(k);
                    hit = 1'b1;
                end
            if (!hit) err = 1'b1;
            v[4*i +: 4] = n;
        end
        if (err)              m_stable = 0;
        else if (v == m_prev) m_stable = (m_stable + 1 > STABLE) ? STABLE : m_stable + 1;
        else                  m_stable = 1;
        m_prev = v;
        pres = (m_stable == STABLE) && (!m_has || (v != m_last));
    endfunction

    task automatic handshake(input logic [4*NDIG-1:0] v);
        chk("val", bus.val, v);
        if (ready_delay > 0) begin
            bus.val_ready = 1'b0;
            for (int k = 0; k < ready_delay; k++) begin
                @(negedge clk);
                chk("hold_valid", bus.val_valid, 1);
                chk("hold_val", bus.val, v);
                chk("hold_dig_en", bus.dig_en, 0);
            end
            bus.val_ready = 1'b1;
        end
        m_has  = 1'b1;
        m_last = v;
        m_val  = v;
        @(negedge clk);
        chk("valid_drop", bus.val_valid, 0);
        chk("val_keep", bus.val, v);
    endtask

    // starts and ends at the negedge of the first SETTLE cycle of a frame
    task automatic do_frame();
        bit                err, pres;
        logic [4*NDIG-1:0] v;
        logic [NDIG-1:0]   oh;
        model_frame(err, v, pres);
        for (int c = 0; c < NDIG * DWELL; c++) begin
            oh = '0;
            oh[c / DWELL] = 1'b1;
            chk("dig_en_scan", bus.dig_en, oh);
            chk("no_err_scan", bus.frame_err, 0);
            @(negedge clk);
        end
        chk("dig_en_check", bus.dig_en, 0);
        chk("frame_err", bus.frame_err, err);
        chk("valid_in_check", bus.val_valid, 0);
        @(negedge clk);
        chk("frame_err_pulse", bus.frame_err, 0);
        chk("val_valid", bus.val_valid, pres);
        if (pres) begin
            if (lat_pending) begin
                chk("latency", cyc - t_en, 1 + STABLE * FRAME);
                lat_pending = 1'b0;
            end
            handshake(v);
        end
    endtask

    task automatic reset_mid();
        repeat (2 * DWELL + 3) @(negedge clk);
        chk("pre_rst_dig2", bus.dig_en, 4'b0100);
        rst = 1'b1;
        #1;
        chk("rst_dig_en", bus.dig_en, 0);
        chk("rst_val", bus.val, 0);
        chk("rst_valid", bus.val_valid, 0);
        m_stable = 0;
        m_prev   = '0;
        m_has    = 1'b0;
        m_val    = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic abort_en(input int off);
        repeat (off) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        chk("abort_dig_en", bus.dig_en, 0);
        chk("abort_val", bus.val, m_val);
        chk("abort_valid", bus.val_valid, 0);
        m_stable = 0;
        m_has    = 1'b0;
        bus.en   = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int r;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.val_ready = 1'b1;
        ready_delay   = 0;
        lat_pending   = 1'b0;
        m_stable      = 0;
        m_prev        = '0;
        m_last        = '0;
        m_val         = '0;
        m_has         = 1'b0;
        disp[3] = 7'h40; disp[2] = 7'h79; disp[1] = 7'h24; disp[0] = 7'h30;

        repeat (3) @(negedge clk);
        chk("reset_dig_en", bus.dig_en, 0);
        chk("reset_val", bus.val, 0);
        chk("reset_valid", bus.val_valid, 0);
        chk("reset_frame_err", bus.frame_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_dig_en", bus.dig_en, 0);

        // 0123: presented once, then held off while unchanged
        bus.en      = 1'b1;
        t_en        = cyc;
        lat_pending = 1'b1;
        @(negedge clk);
        repeat (4) do_frame();

        // digit 0 -> F gives 012F
        disp[0] = 7'h0E;
        repeat (3) do_frame();

        // blank digit 2 errors every frame, then a new valid value
        disp[2] = 7'h7F;
        repeat (3) do_frame();
        disp[2] = 7'h24;
        repeat (3) do_frame();

        // long back-pressure on the next value
        disp[1]     = 7'h30;
        ready_delay = 50;
        repeat (2) do_frame();
        ready_delay = 0;

        // reset on digit 2; same value comes out again
        do_frame();
        reset_mid();
        repeat (3) do_frame();

        // digit 1 flickering never stabilises
        for (int f = 0; f < 6; f++) begin
            disp[1] = (f % 2 != 0) ? 7'h24 : 7'h79;
            do_frame();
        end

        // drop en mid-scan; presentation memory is forgotten
        abort_en(13);
        repeat (3) do_frame();

        // randomized patterns, bad glyphs, back-pressure and en drops
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 9);
            if (r < 4)
                disp[$urandom_range(0, NDIG - 1)] = CODES[$urandom_range(0, 15)];
            else if (r == 4)
                disp[$urandom_range(0, NDIG - 1)] = 7'($urandom);
            ready_delay = $urandom_range(0, 4);
            if (r == 9) abort_en($urandom_range(0, NDIG * DWELL - 1));
            do_frame();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
